// File: rtl/dobbelsteen_roll_core.sv
// Dice roll engine: free-running Galois LFSR, spin animation, bounded-reject
// unbiased pick of a face 1..6, pip decode and status flags for the AXI slave.
module dobbelsteen_roll_core #(
   parameter int          SPIN_STEPS = 8,
   parameter int          SPIN_DIV   = 4,
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter int          COUNT_W    = 16
) (
   input  logic               ACLK,
   input  logic               ARESETN,
   input  logic               roll_req,
   input  logic               seed_load,
   input  logic [15:0]        seed_val,
   input  logic               clr_status,
   output logic [2:0]         face,
   output logic [6:0]         pips,
   output logic               busy,
   output logic               done,
   output logic               overrun,
   output logic [COUNT_W-1:0] roll_count
);

   localparam int STEP_W = $clog2(SPIN_STEPS + 1);
   localparam int DIV_W  = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SPIN_STEPS - 1);
   localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(SPIN_DIV - 1);

   typedef enum logic [1:0] {IDLE, SPIN, PICK, DONE} state_t;

   state_t            state;
   logic [15:0]       lfsr;
   logic [STEP_W-1:0] step_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [1:0]        rej_cnt;
   logic [2:0]        cand;

   assign cand = lfsr[2:0];

   // The LFSR never stops, so the pick depends on how long the user waited.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)
         lfsr <= SEED;
      else if (seed_load)
         lfsr <= (seed_val == 16'h0000) ? SEED : seed_val;
      else
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= IDLE;
         step_cnt   <= '0;
         div_cnt    <= '0;
         rej_cnt    <= '0;
         face       <= 3'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         roll_count <= '0;
      end else begin
         done <= 1'b0;
         // A busy request outranks a simultaneous clear.
         if (roll_req && state != IDLE)
            overrun <= 1'b1;
         else if (clr_status)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (roll_req) begin
                  state    <= SPIN;
                  busy     <= 1'b1;
                  step_cnt <= '0;
                  div_cnt  <= DIV_LOAD;
               end
            end
            SPIN: begin
               if (div_cnt == '0) begin
                  face     <= (face == 3'd6 || face == 3'd0) ? 3'd1 : face + 3'd1;
                  step_cnt <= step_cnt + 1'b1;
                  div_cnt  <= DIV_LOAD;
                  if (step_cnt == LAST_STEP) begin
                     state   <= PICK;
                     rej_cnt <= 2'd0;
                  end
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            PICK: begin
               if (cand < 3'd6) begin
                  face  <= cand + 3'd1;
                  state <= DONE;
                  done  <= 1'b1;
               end else if (rej_cnt == 2'd3) begin
                  // Fourth reject in a row: fold 6/7 onto 3/4 to bound latency.
                  face  <= {1'b0, cand[1:0]} + 3'd1;
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  rej_cnt <= rej_cnt + 2'd1;
               end
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               roll_count <= roll_count + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bit order TL,TR,ML,C,MR,BL,BR = [0]..[6].
   always_comb begin
      pips = 7'h00;
      case (face)
         3'd1:    pips = 7'h08;
         3'd2:    pips = 7'h41;
         3'd3:    pips = 7'h49;
         3'd4:    pips = 7'h63;
         3'd5:    pips = 7'h6B;
         3'd6:    pips = 7'h77;
         default: pips = 7'h00;
      endcase
   end

endmodule

// File: tb/tb_dobbelsteen_roll_core.sv
// Scoreboard bench for dobbelsteen_roll_core: stimulus predicts each roll's
// final face and done cycle, a monitor pops and compares on every done pulse.
module tb_dobbelsteen_roll_core;

   localparam int CW = 4;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b1;
   logic          roll_req = 1'b0;
   logic          seed_load = 1'b0;
   logic [15:0]   seed_val = 16'h0000;
   logic          clr_status = 1'b0;
   logic [2:0]    face;
   logic [6:0]    pips;
   logic          busy;
   logic          done;
   logic          overrun;
   logic [CW-1:0] roll_count;

   dobbelsteen_roll_core #(
      .SPIN_STEPS(8), .SPIN_DIV(4), .SEED(16'hACE1), .COUNT_W(CW)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .roll_req(roll_req), .seed_load(seed_load),
      .seed_val(seed_val), .clr_status(clr_status), .face(face), .pips(pips),
      .busy(busy), .done(done), .overrun(overrun), .roll_count(roll_count)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [2:0]    face;
      logic [6:0]    pips;
      int            cyc;
      logic [CW-1:0] count;
   } sb_t;

   sb_t           sbq[$];
   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;
   logic [15:0]   m_lfsr;
   logic [CW-1:0] exp_count = '0;
   logic [2:0]    last_face = 3'd0;
   logic [6:0]    seen = 7'h00;
   bit            pend_vld = 1'b0;
   int            pend_cyc = 0;
   logic [CW-1:0] pend_count = '0;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [6:0] pip_of(input logic [2:0] f);
      case (f)
         3'd1: return 7'h08;
         3'd2: return 7'h41;
         3'd3: return 7'h49;
         3'd4: return 7'h63;
         3'd5: return 7'h6B;
         3'd6: return 7'h77;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [2:0] adv(input logic [2:0] f);
      return (f == 3'd6 || f == 3'd0) ? 3'd1 : f + 3'd1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge ACLK) cyc <= cyc + 1;

   // Reference LFSR, kept in lockstep with the bench's own strobes.
   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)       m_lfsr <= 16'hACE1;
      else if (seed_load) m_lfsr <= (seed_val == 16'h0000) ? 16'hACE1 : seed_val;
      else                m_lfsr <= lfsr_step(m_lfsr);
   end

   // Monitor
   always @(negedge ACLK) begin
      sb_t e;
      if (pend_vld && cyc == pend_cyc) begin
         check("roll_count", roll_count, pend_count);
         pend_vld = 1'b0;
      end
      if (ARESETN && done) begin
         if (sbq.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sbq.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("final_face", face, e.face);
            check("final_pips", pips, e.pips);
            seen[face] = 1'b1;
            pend_vld   = 1'b1;
            pend_cyc   = cyc + 1;
            pend_count = e.count;
         end
      end
   end

   // Issue one roll at the current negedge, predict and push its outcome, and
   // drive the optional side strobes at their relative cycles.
   task automatic run_roll(input int seed_at, input logic [15:0] sv, input int ovr_at,
                           input bit ovr_clr, input bit req_at_done);
      sb_t         e;
      int          n, d, r, k;
      logic [15:0] l;
      logic [2:0]  f, c, ef;
      roll_req = 1'b1;
      n = cyc + 1;
      if (seed_at > 0) begin
         l = (sv == 16'h0000) ? 16'hACE1 : sv;
         repeat (32 - seed_at) l = lfsr_step(l);
      end else begin
         l = m_lfsr;
         repeat (33) l = lfsr_step(l);
      end
      f = 3'd0;
      r = 0;
      for (int i = 0; i < 4; i++) begin
         c = l[2:0];
         r = i;
         if (c < 3'd6) begin
            f = c + 3'd1;
            break;
         end
         if (i == 3) begin
            f = {1'b0, c[1:0]} + 3'd1;
            break;
         end
         l = lfsr_step(l);
      end
      d = n + 33 + r;
      e.face  = f;
      e.pips  = pip_of(f);
      e.cyc   = d;
      e.count = exp_count + 1'b1;
      exp_count = e.count;
      sbq.push_back(e);

      @(negedge ACLK);
      roll_req = 1'b0;
      check("busy_set", busy, 1);
      while (cyc < d + 1) begin
         seed_load  = (seed_at > 0 && cyc == n + seed_at - 1);
         seed_val   = sv;
         roll_req   = (ovr_at > 0 && cyc == n + ovr_at - 1) || (req_at_done && cyc == d);
         clr_status = ovr_clr && ovr_at > 0 && cyc == n + ovr_at - 1;
         if (cyc > n && (cyc - n) % 4 == 0 && cyc <= n + 32) begin
            k  = (cyc - n) / 4;
            ef = last_face;
            repeat (k) ef = adv(ef);
            check("spin_face", face, ef);
         end
         if (ovr_at > 0 && cyc == n + ovr_at) check("overrun_set", overrun, 1);
         @(negedge ACLK);
      end
      roll_req   = 1'b0;
      seed_load  = 1'b0;
      clr_status = 1'b0;
      check("busy_clear", busy, 0);
      if (req_at_done) check("overrun_done_req", overrun, 1);
      last_face = f;
   endtask

   task automatic clear_overrun();
      clr_status = 1'b1;
      @(negedge ACLK);
      clr_status = 1'b0;
      check("overrun_clr", overrun, 0);
   endtask

   initial begin
      int n;
      logic [2:0] ef;
      #2 ARESETN = 1'b0;
      #1;
      check("rst_face", face, 0);
      check("rst_pips", pips, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_count", roll_count, 0);
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      check("rst_lfsr", dut.lfsr, 16'hACE1);

      // Roll from reset with face-step and timing checks.
      run_roll(0, 16'h0, 0, 1'b0, 1'b0);
      @(negedge ACLK);

      // Overrun during spin, then clear.
      run_roll(0, 16'h0, 10, 1'b0, 1'b0);
      clear_overrun();

      // Clear together with a busy request: the set wins.
      run_roll(0, 16'h0, 10, 1'b1, 1'b0);
      clear_overrun();

      // Request landing on the DONE cycle is ignored.
      run_roll(0, 16'h0, 0, 1'b0, 1'b1);
      clear_overrun();

      // Seed of zero falls back to the default seed.
      seed_load = 1'b1;
      seed_val  = 16'h0000;
      @(negedge ACLK);
      seed_load = 1'b0;
      check("seed_zero", dut.lfsr, 16'hACE1);
      @(negedge ACLK);

      // Reseed mid-spin: timing unchanged, pick follows the new sequence.
      run_roll(12, 16'h1234, 0, 1'b0, 1'b0);
      check("lfsr_track", dut.lfsr, m_lfsr);

      // Asynchronous reset during cycle 15 of a roll.
      roll_req = 1'b1;
      n = cyc + 1;
      @(negedge ACLK);
      roll_req = 1'b0;
      while (cyc < n + 15) @(negedge ACLK);
      ef = adv(adv(adv(last_face)));
      check("pre_rst_busy", busy, 1);
      check("pre_rst_face", face, ef);
      #2 ARESETN = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_face", face, 0);
      check("arst_pips", pips, 0);
      check("arst_count", roll_count, 0);
      exp_count = '0;
      last_face = 3'd0;
      @(negedge ACLK);
      ARESETN = 1'b1;
      check("arst_lfsr", dut.lfsr, 16'hACE1);
      run_roll(0, 16'h0, 0, 1'b0, 1'b0);

      // Bulk rolls with varying idle gaps; count wraps every 16 rolls.
      for (int i = 0; i < 200; i++) begin
         repeat (i % 4) @(negedge ACLK);
         run_roll(0, 16'h0, 0, 1'b0, 1'b0);
      end

      repeat (5) @(negedge ACLK);
      check("scoreboard_empty", sbq.size(), 0);
      check("faces_seen", seen, 7'h7E);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dobbelsteen_roll_core.md
# dobbelsteen_roll_core

Dice roll engine behind the DobbelSteen AXI4-Lite register slave. It consumes the roll, seed and status-clear strobes decoded from the slave registers and produces the die face, the LED pip pattern and the status flags the slave exposes for read-back. A free-running 16-bit LFSR drives the roll. Each roll plays a spin animation, then picks an unbiased face from 1 to 6.

## Interface
- SPIN_STEPS, 8: number of animation face changes per roll (≥1)
- SPIN_DIV, 4: clock cycles per animation step (≥1)
- SEED, 16'hACE1: LFSR reset/default seed (nonzero)
- COUNT_W, 16: width of the completed-roll counter
- ACLK, in, 1: clock; single clock domain
- ARESETN, in, 1: reset, asynchronous assert, active-low
- roll_req, in, 1: one-cycle roll strobe (slave write of reg0 bit0)
- seed_load, in, 1: one-cycle strobe, load seed_val into LFSR
- seed_val, in, 16: seed value
- clr_status, in, 1: one-cycle strobe, clears overrun
- face, out, 3: current face (0 = never rolled, 1..6)
- pips, out, 7: LED pattern, bit order TL,TR,ML,C,MR,BL,BR = [0]..[6]
- busy, out, 1: roll in progress
- done, out, 1: one-cycle pulse, final face valid
- overrun, out, 1: sticky, roll_req seen while busy
- roll_count, out, COUNT_W: completed rolls, wraps to 0

## Operation
- LFSR: Galois, right shift. Next value = {0, lfsr[15:1]}, XOR 16'hB400 when lfsr[0]=1.
  - Advances every cycle, in all states.
  - seed_load overrides the advance in that cycle, in any state; the FSM is unaffected.
  - seed_val = 0 loads SEED instead.
- FSM states: IDLE, SPIN, PICK, DONE.
  - IDLE: roll_req=1 → SPIN. Clear the step counter; set the div counter to SPIN_DIV-1.
  - SPIN: the div counter decrements each cycle. At 0 it does three things:
    - advances face (face==6 or face==0 → 1, else face+1);
    - increments the step counter and reloads SPIN_DIV-1;
    - goes to PICK after the SPIN_STEPS-th step.
  - PICK: cand = lfsr[2:0].
    - cand<6: face ← cand+1, go to DONE.
    - Otherwise reject and stay in PICK.
    - On the 4th consecutive reject: face ← cand[1:0]+1, go to DONE. This bounds PICK to 4 cycles.
  - DONE: done=1, roll_count ← roll_count+1 (modulo 2^COUNT_W), go to IDLE.
- busy = (state != IDLE), registered with the state.
- roll_req while busy: ignored, and overrun ← 1.
  - clr_status clears overrun.
  - If clr_status and a busy roll_req occur in the same cycle, the set wins.
- roll_req in the same cycle as DONE is ignored and sets overrun.
- pips: combinational decode of the face register.
  - 0 → 7'h00
  - 1 → 7'h08
  - 2 → 7'h41
  - 3 → 7'h49
  - 4 → 7'h63
  - 5 → 7'h6B
  - 6 → 7'h77
  - 7 → 7'h00
- Reset mid-roll aborts immediately to reset values; no done pulse is produced.

## Timing
- Reset values:
  - face=0, pips=0, busy=0, done=0, overrun=0, roll_count=0;
  - lfsr=SEED, state=IDLE, counters 0.
- roll_req sampled at edge N: busy=1 from edge N+1.
- Face changes occur at edges N+SPIN_DIV·k, for k=1..SPIN_STEPS.
- PICK occupies 1 to 4 cycles, starting at edge N+SPIN_DIV·SPIN_STEPS.
- DONE lasts 1 cycle. done and the final face are valid together; roll_count updates on the edge that leaves DONE.
- busy drops on the edge after DONE. A new roll_req is accepted from that cycle on.
- Total roll with defaults: 32 SPIN cycles + 1..4 PICK cycles + 1 DONE cycle, i.e. 34..37 cycles after the req edge.
- Strobes are level-sampled each edge. A roll_req held high in IDLE starts exactly one roll; the extra cycles then set overrun.

## Test plan
- Reset: assert ARESETN=0 asynchronously mid-cycle.
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, lfsr=16'hACE1; the bench reads it through a debug probe or reference model.
- Roll with defaults from reset:
  - face steps through 1,2,3,4,5,6,1,2 at 4-cycle intervals;
  - done pulses exactly once, 34..37 cycles after roll_req;
  - the final face matches a bench LFSR model including the reject rule;
  - roll_count=1; pips match the decode table.
- Pip decode: run 200 rolls and check pips against the table for every observed face. All faces 1..6 must occur, and face must never be 0 or 7 after the first roll.
- Overrun:
  - roll_req at cycle 10 of a roll → overrun=1, roll continues, and a single done pulse occurs.
  - clr_status → overrun=0.
  - clr_status in the same cycle as a busy roll_req → overrun stays 1.
- Seed:
  - seed_load with seed_val=0 → LFSR equals 16'hACE1 on the next cycle.
  - seed_load with 16'h1234 during SPIN → FSM timing is unchanged, and the PICK result follows the reseeded model.
- Reset mid-SPIN and counter wrap:
  - ARESETN low during cycle 15 of a roll → busy=0, no done pulse; the next roll after release behaves as in the from-reset case.
  - With COUNT_W=4, 16 rolls → roll_count returns to 0.
